// File: rtl/bidir_port_ctrl.sv
// Bidirectional bus port controller: serialises single-word writes (drive) and
// reads (sample) on a shared tristate bus, inserting released turnaround cycles.
// Latency: write drives cycles k+1..k+DRIVE_CYCLES; read data valid in cycle k+2.
// Backpressure: wr_ready is high only in IDLE; requests outside IDLE are ignored.
module bidir_port_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int DRIVE_CYCLES = 1,
  parameter int TURN_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  bus_oe,
  output logic                  busy
);

  // Counter must be able to hold the longer of the two timed phases.
  localparam int CNT_MAX = (DRIVE_CYCLES > TURN_CYCLES) ? DRIVE_CYCLES : TURN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal counts for the timed phases (counter runs 0..N-1).
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LAST  = CNT_W'((TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_READ  = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_wr_acc;
  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  w_drive;

  // Next-state and phase counter; a write always beats a simultaneous read.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_acc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (wr_req) begin
          w_wr_acc    = 1'b1;
          w_state_nxt = S_DRIVE;
        end else if (rd_req) begin
          w_state_nxt = S_READ;
        end
      end
      S_DRIVE: begin
        if (r_cnt == DRIVE_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (TURN_CYCLES == 0) ? S_IDLE : S_TURN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_READ: begin
        w_cnt_nxt   = '0;
        w_state_nxt = (TURN_CYCLES == 0) ? S_IDLE : S_TURN;
      end
      S_TURN: begin
        if (r_cnt == TURN_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset drops straight to IDLE with no turnaround.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output word is captured only on acceptance so wr_data may change during DRIVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (w_wr_acc) begin
      r_out <= wr_data;
    end
  end

  // Sample the bus at the edge ending READ; strobe rd_valid for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == S_READ);
      if (r_state == S_READ) begin
        r_rd_data <= data;
      end
    end
  end

  // Bus enable decoded from registered state only: glitch-free, no input paths.
  assign w_drive  = (r_state == S_DRIVE);
  assign bus_oe   = w_drive;
  assign data     = w_drive ? r_out : {DATA_WIDTH{1'bz}};
  assign wr_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Bench for bidir_port_ctrl: three instances (D1/T1, D3/T0, D2/T2) with directed
// stimulus; expected bus words and read words are queued at issue time and a
// negedge monitor pops and compares whenever a DUT drives the bus or strobes rd_valid.
module tb_bidir_port_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  // instance 0: D=1, T=1 (externally drivable bus)
  logic       wr_req0, rd_req0, wr_ready0, rd_valid0, bus_oe0, busy0;
  logic [7:0] wr_data0, rd_data0;
  logic       tb_en0;
  logic [7:0] tb_drv0;
  wire  [7:0] bus0;
  assign bus0 = tb_en0 ? tb_drv0 : 8'bz;

  // instance 1: D=3, T=0
  logic       wr_req1, rd_req1, wr_ready1, rd_valid1, bus_oe1, busy1;
  logic [7:0] wr_data1, rd_data1;
  wire  [7:0] bus1;

  // instance 2: D=2, T=2
  logic       wr_req2, rd_req2, wr_ready2, rd_valid2, bus_oe2, busy2;
  logic [7:0] wr_data2, rd_data2;
  wire  [7:0] bus2;

  logic [7:0] q_drv0[$];
  logic [7:0] q_drv1[$];
  logic [7:0] q_drv2[$];
  logic [7:0] q_rd0[$];

  bidir_port_ctrl #(.DATA_WIDTH(8), .DRIVE_CYCLES(1), .TURN_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .wr_req(wr_req0), .wr_data(wr_data0), .wr_ready(wr_ready0),
    .rd_req(rd_req0), .rd_data(rd_data0), .rd_valid(rd_valid0), .data(bus0),
    .bus_oe(bus_oe0), .busy(busy0));

  bidir_port_ctrl #(.DATA_WIDTH(8), .DRIVE_CYCLES(3), .TURN_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .wr_req(wr_req1), .wr_data(wr_data1), .wr_ready(wr_ready1),
    .rd_req(rd_req1), .rd_data(rd_data1), .rd_valid(rd_valid1), .data(bus1),
    .bus_oe(bus_oe1), .busy(busy1));

  bidir_port_ctrl #(.DATA_WIDTH(8), .DRIVE_CYCLES(2), .TURN_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .wr_req(wr_req2), .wr_data(wr_data2), .wr_ready(wr_ready2),
    .rd_req(rd_req2), .rd_data(rd_data2), .rd_valid(rd_valid2), .data(bus2),
    .bus_oe(bus_oe2), .busy(busy2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s unexpected output value=%0h at %0t", name, act, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops one expected word per driven cycle / per rd_valid strobe.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_oe0 && tb_en0) unexpected("overlap0", 32'(bus0));
      if (bus_oe0) begin
        if (q_drv0.size() == 0) unexpected("drv0", 32'(bus0));
        else check("drv0", 32'(bus0), 32'(q_drv0.pop_front()));
      end
      if (rd_valid0) begin
        if (q_rd0.size() == 0) unexpected("rd0", 32'(rd_data0));
        else check("rd0", 32'(rd_data0), 32'(q_rd0.pop_front()));
      end
      if (bus_oe1) begin
        if (q_drv1.size() == 0) unexpected("drv1", 32'(bus1));
        else check("drv1", 32'(bus1), 32'(q_drv1.pop_front()));
      end
      if (bus_oe2) begin
        if (q_drv2.size() == 0) unexpected("drv2", 32'(bus2));
        else check("drv2", 32'(bus2), 32'(q_drv2.pop_front()));
      end
      if (rd_valid1) unexpected("rd1", 32'(rd_data1));
      if (rd_valid2) unexpected("rd2", 32'(rd_data2));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    wr_req0 = 0; rd_req0 = 0; wr_data0 = '0; tb_en0 = 0; tb_drv0 = '0;
    wr_req1 = 0; rd_req1 = 0; wr_data1 = '0;
    wr_req2 = 0; rd_req2 = 0; wr_data2 = '0;

    // ---- reset: held 2 cycles
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_bus_oe", 32'(bus_oe0), 0);
    check("rst_wr_ready", 32'(wr_ready0), 1);
    check("rst_busy", 32'(busy0), 0);
    check("rst_rd_data", 32'(rd_data0), 32'h00);
    check("rst_rd_valid", 32'(rd_valid0), 0);
    check("rst_wr_ready1", 32'(wr_ready1), 1);
    check("rst_wr_ready2", 32'(wr_ready2), 1);
    tick;

    // ---- write 0xA5 on D=1,T=1
    wr_req0 = 1; wr_data0 = 8'hA5; q_drv0.push_back(8'hA5);
    @(negedge clk);
    check("wr_ready_before", 32'(wr_ready0), 1);
    tick;                                 // edge k accepted, cycle k+1
    wr_req0 = 0; wr_data0 = 8'h00;
    @(negedge clk);
    check("wr_busy_k1", 32'(busy0), 1);
    check("wr_ready_k1", 32'(wr_ready0), 0);
    tick;                                 // cycle k+2: released turnaround
    @(negedge clk);
    check("wr_oe_k2", 32'(bus_oe0), 0);
    check("wr_ready_k2", 32'(wr_ready0), 0);
    tick;                                 // cycle k+3
    @(negedge clk);
    check("wr_ready_k3", 32'(wr_ready0), 1);
    tick;

    // ---- read 0x3C on D=1,T=1
    tb_en0 = 1; tb_drv0 = 8'h3C;
    rd_req0 = 1; q_rd0.push_back(8'h3C);
    tick;                                 // edge k accepted, cycle k+1 READ
    rd_req0 = 0;
    @(negedge clk);
    check("rd_busy_k1", 32'(busy0), 1);
    check("rd_valid_k1", 32'(rd_valid0), 0);
    tick;                                 // cycle k+2: rd_valid
    tb_en0 = 0; tb_drv0 = 8'h00;
    @(negedge clk);
    check("rd_valid_k2", 32'(rd_valid0), 1);
    tick;                                 // cycle k+3
    @(negedge clk);
    check("rd_hold", 32'(rd_data0), 32'h3C);
    check("rd_valid_k3", 32'(rd_valid0), 0);
    check("rd_idle_k3", 32'(wr_ready0), 1);
    tick;

    // ---- simultaneous request: write wins, read dropped
    wr_req0 = 1; rd_req0 = 1; wr_data0 = 8'h5A; q_drv0.push_back(8'h5A);
    tick;
    wr_req0 = 0; rd_req0 = 0;
    repeat (4) tick;
    @(negedge clk);
    check("sim_idle", 32'(wr_ready0), 1);
    check("sim_rd_data", 32'(rd_data0), 32'h3C);
    tick;

    // ---- D=3, T=0: wr_data changed mid-drive must not reach the bus
    wr_req1 = 1; wr_data1 = 8'h81;
    repeat (3) q_drv1.push_back(8'h81);
    tick;                                 // edge k, cycle k+1
    wr_req1 = 0; wr_data1 = 8'h7E;
    tick;                                 // k+2
    tick;                                 // k+3 last driven
    @(negedge clk);
    check("d3_ready_k3", 32'(wr_ready1), 0);
    tick;                                 // k+4: IDLE with no gap
    @(negedge clk);
    check("d3_ready_k4", 32'(wr_ready1), 1);
    check("d3_oe_k4", 32'(bus_oe1), 0);
    tick;

    // ---- D=2, T=2
    wr_req2 = 1; wr_data2 = 8'hC3;
    repeat (2) q_drv2.push_back(8'hC3);
    tick;                                 // edge k, cycle k+1
    wr_req2 = 0;
    tick;                                 // k+2
    tick;                                 // k+3 turnaround
    @(negedge clk);
    check("d2t2_oe_k3", 32'(bus_oe2), 0);
    check("d2t2_ready_k3", 32'(wr_ready2), 0);
    tick;                                 // k+4 turnaround
    @(negedge clk);
    check("d2t2_ready_k4", 32'(wr_ready2), 0);
    tick;                                 // k+5
    @(negedge clk);
    check("d2t2_ready_k5", 32'(wr_ready2), 1);
    tick;

    // ---- reset in the 2nd cycle of a D=3 drive
    wr_req1 = 1; wr_data1 = 8'h99;
    repeat (2) q_drv1.push_back(8'h99);
    tick;                                 // edge k, cycle k+1
    wr_req1 = 0;
    tick;                                 // k+2: second driven cycle
    rst = 1;
    tick;                                 // reset edge, cycle k+3
    rst = 0;
    @(negedge clk);
    check("rmd_oe", 32'(bus_oe1), 0);
    check("rmd_busy", 32'(busy1), 0);
    check("rmd_ready", 32'(wr_ready1), 1);
    tick;

    // ---- reset during READ suppresses rd_valid and clears rd_data
    tb_en0 = 1; tb_drv0 = 8'h77;
    rd_req0 = 1;
    tick;                                 // accepted, cycle READ
    rd_req0 = 0; rst = 1;
    tick;                                 // reset edge
    rst = 0; tb_en0 = 0;
    @(negedge clk);
    check("rrd_valid", 32'(rd_valid0), 0);
    check("rrd_data", 32'(rd_data0), 32'h00);
    check("rrd_busy", 32'(busy0), 0);
    tick;

    // ---- request at a reset edge is discarded
    rst = 1; wr_req0 = 1; wr_data0 = 8'hEE;
    tick;
    rst = 0; wr_req0 = 0;
    @(negedge clk);
    check("rreq_busy", 32'(busy0), 0);
    check("rreq_oe", 32'(bus_oe0), 0);
    repeat (3) tick;

    // ---- every expected word must have been observed
    check("drained_drv0", 32'(q_drv0.size()), 0);
    check("drained_drv1", 32'(q_drv1.size()), 0);
    check("drained_drv2", 32'(q_drv2.size()), 0);
    check("drained_rd0", 32'(q_rd0.size()), 0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bidir_port_ctrl.md
BIDIR_PORT_CTRL -- requirements
Module: bidir_port_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the bidirectional bus and both data paths; legal range 1 to 64.
REQ-002 Parameter DRIVE_CYCLES, default 1: number of cycles each accepted write word is driven onto the bus; legal minimum 1.
REQ-003 Parameter TURN_CYCLES, default 1: number of bus-released turnaround cycles after every drive or read; 0 is legal.
REQ-004 Port: clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 Port: rst  input  1  reset, synchronous and active-high.
REQ-006 Port: wr_req  input  1  write request; a transfer is accepted when wr_req and wr_ready are both high at a rising edge.
REQ-007 Port: wr_data  input  DATA_WIDTH  word to drive; captured only on acceptance.
REQ-008 Port: wr_ready  output  1  high only in IDLE.
REQ-009 Port: rd_req  input  1  read request; accepted in IDLE only when a write is not accepted at the same edge.
REQ-010 Port: rd_data  output  DATA_WIDTH  last sampled bus value; held until the next sample.
REQ-011 Port: rd_valid  output  1  one-cycle strobe marking new rd_data.
REQ-012 Port: data  inout  DATA_WIDTH  bidirectional bus; all bits high-Z when not driving.
REQ-013 Port: bus_oe  output  1  high exactly when the block drives data.
REQ-014 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, DRIVE, READ and TURN, with a cycle counter sized to hold max(DRIVE_CYCLES, TURN_CYCLES).
REQ-016 IDLE: bus released. A write accept captures wr_data into out_reg and moves to DRIVE with counter=0. Otherwise rd_req moves to READ. Otherwise the FSM stays in IDLE.
REQ-017 When wr_req and rd_req are both high in IDLE, the write SHALL win; the read is not queued and must be re-requested.
REQ-018 DRIVE: bus_oe=1 and data=out_reg for exactly DRIVE_CYCLES cycles, then go to TURN, or to IDLE if TURN_CYCLES=0; requests are ignored.
REQ-019 READ: lasts 1 cycle with the bus released. At the rising edge ending READ, rd_data <= data and rd_valid=1 for the following cycle only. Then go to TURN, or to IDLE if TURN_CYCLES=0.
REQ-020 TURN: bus released for exactly TURN_CYCLES cycles, then go to IDLE; requests are ignored.
REQ-021 Write latency: if accepted at edge k, the bus is driven from cycle k+1 through cycle k+DRIVE_CYCLES, and wr_ready returns high after DRIVE_CYCLES+TURN_CYCLES cycles.
REQ-022 Read latency: if rd_req is accepted at edge k, rd_valid is high in cycle k+2 only, with rd_data equal to the bus value sampled at edge k+1.
REQ-023 bus_oe and the data tristate SHALL be decoded from the registered state only, so they are glitch-free and have no combinational path from any input.
REQ-024 out_reg SHALL change only on write acceptance, so wr_data changes during DRIVE do not affect the bus.
REQ-025 Back-to-back operations SHALL always be separated by at least TURN_CYCLES released cycles plus one IDLE cycle; the bus is never driven in two consecutive operations without that gap.

Reset
REQ-026 While rst is high at a rising edge: state=IDLE, counter=0, out_reg=0, rd_data=0, rd_valid=0. Outputs from the next cycle: bus_oe=0, data high-Z, busy=0, wr_ready=1.
REQ-027 Reset asserted mid-DRIVE SHALL release the bus on the cycle after the reset edge, with no turnaround.
REQ-028 Reset asserted in READ SHALL suppress the pending rd_valid.
REQ-029 Requests sampled at a reset edge SHALL be discarded.

Verification
REQ-030 Reset scenario: W=8, D=1, T=1; rst held 2 cycles -> data=Z, bus_oe=0, wr_ready=1, rd_data=0x00.
REQ-031 Write scenario: wr_req with wr_data=0xA5 accepted at edge k -> data=0xA5 in cycle k+1 only, Z in k+2, wr_ready high again in cycle k+3.
REQ-032 Read scenario: bench drives data=0x3C, rd_req accepted at edge k -> rd_valid=1 and rd_data=0x3C in cycle k+2; rd_data holds 0x3C afterwards.
REQ-033 Simultaneous-request scenario: wr_req and rd_req both high in IDLE with wr_data=0x5A -> 0x5A is driven and no rd_valid follows.
REQ-034 Parameter scenario: D=3, T=0 -> data driven for exactly 3 cycles, then IDLE with no gap; D=2, T=2 -> 2 cycles driven then 2 cycles Z before wr_ready.
REQ-035 Reset-mid-drive scenario: rst asserted in the 2nd cycle of a D=3 drive -> Z on the next cycle, FSM in IDLE, no rd_valid; bench monitor confirms bus_oe and external drive never overlap in any scenario.
